brdg_tlx_cmd_arbiter: RTL and testbench

- Shares the single AFU->TLX command port between four requesters, in fixed order: 0 = assign_actag (from the context-surveil logic), 1 = write, 2 = read, 3 = interrupt.
- Owns the TLX command-credit counter.
- Enforces a configurable quiet gap after every assign_actag so no data command that depends on the acTag races it.
- Sits between the bridge command generators and the TLX AFU-command interface.

---
 rtl/brdg_tlx_cmd_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_brdg_tlx_cmd_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brdg_tlx_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// brdg_tlx_cmd_arbiter
//
// Shares the single AFU->TLX command port between four requesters:
//   0 = assign_actag, 1 = write, 2 = read, 3 = interrupt.
// assign_actag has strict priority. The three data requesters are served
// round-robin. After every assign_actag issue, the data requesters are held
// off for ACTAG_GAP cycles so that no command that uses the new acTag can
// overtake it. The block also owns the TLX command-credit counter.
//
// Optional feature: define BRDG_CMD_ARB_STAT_EN to build per-requester
// 32-bit grant counters. When it is undefined, grant_cnt_* read as 0 and no
// counter flops are built.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tlx_afu_cmd_initial_credit  credits advertised by TLX, loaded in S_INIT
//   tlx_afu_cmd_credit          one credit returned this cycle
//   <req>_valid/_cmd/_ready     requester handshakes (actag, wr, rd, intrp);
//                               ready is combinational and one-hot or zero
//   afu_tlx_cmd_valid/_bus      registered command to TLX, one cycle after
//                               grant; the bus holds its value when idle
//   credit_cnt                  credits currently available (0..16)
//   credit_ovf_err              sticky: credit returned while already at 16
//   grant_cnt_*                 per-requester grant statistics
// -----------------------------------------------------------------------------
module brdg_tlx_cmd_arbiter #(
    parameter int CMD_W     = 128,
    parameter int CREDIT_W  = 5,
    parameter int ACTAG_GAP = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          tlx_afu_cmd_initial_credit,
    input  logic                tlx_afu_cmd_credit,
    input  logic                actag_valid,
    input  logic [CMD_W-1:0]    actag_cmd,
    output logic                actag_ready,
    input  logic                wr_valid,
    input  logic [CMD_W-1:0]    wr_cmd,
    output logic                wr_ready,
    input  logic                rd_valid,
    input  logic [CMD_W-1:0]    rd_cmd,
    output logic                rd_ready,
    input  logic                intrp_valid,
    input  logic [CMD_W-1:0]    intrp_cmd,
    output logic                intrp_ready,
    output logic                afu_tlx_cmd_valid,
    output logic [CMD_W-1:0]    afu_tlx_cmd_bus,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic                credit_ovf_err,
    output logic [31:0]         grant_cnt_actag,
    output logic [31:0]         grant_cnt_wr,
    output logic [31:0]         grant_cnt_rd,
    output logic [31:0]         grant_cnt_intrp
);

    localparam int NUM_REQ = 4;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(16);
    localparam logic [3:0]          GAP_LOAD   = 4'(ACTAG_GAP);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    // Round-robin pointer encoding over the data requesters.
    localparam logic [1:0] RR_WR = 2'd0;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    state_e                           state_q, state_d;
    logic [3:0]                       gap_q, gap_d;
    logic [1:0]                       ptr_q, ptr_d;
    logic [CREDIT_W-1:0]              credit_q, credit_d;
    logic                             ovf_q, ovf_d;
    logic                             cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0]                 cmd_bus_q, cmd_bus_d;

    logic [NUM_REQ-1:0]               grant;
    logic [NUM_REQ-1:0][CMD_W-1:0]    req_cmd;
    logic [3:0]                       dat_vld;
    logic                             can_grant;
    logic                             any_grant;
    logic [1:0]                       idx;
    logic                             found;

    assign req_cmd   = {intrp_cmd, rd_cmd, wr_cmd, actag_cmd};
    assign dat_vld   = {1'b0, intrp_valid, rd_valid, wr_valid};
    // Reset gates grants combinationally so an in-flight request is dropped
    // rather than issued into the reset edge.
    assign can_grant = !rst && (state_q != S_INIT) && (credit_q != '0);
    assign any_grant = |grant;

    // -------------------------------------------------------------------------
    // Arbitration and FSM next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        grant   = '0;
        idx     = ptr_q;
        found   = 1'b0;

        unique case (state_q)
            S_INIT: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                if (can_grant) begin
                    if (actag_valid) begin
                        grant[0] = 1'b1;
                    end else begin
                        // Scan wr/rd/intrp starting at the pointer.
                        for (int k = 0; k < 3; k++) begin
                            if (!found && dat_vld[idx]) begin
                                found                = 1'b1;
                                grant[idx + 2'd1]    = 1'b1;
                                ptr_d                = rr_next(idx);
                            end
                            idx = rr_next(idx);
                        end
                    end
                end
                if (grant[0] && (ACTAG_GAP != 0)) begin
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (can_grant && actag_valid) begin
                    grant[0] = 1'b1;
                end
                if (grant[0]) begin
                    // A back-to-back assign_actag restarts the quiet window.
                    gap_d = GAP_LOAD;
                end else begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q <= 4'd1) begin
                        state_d = S_RUN;
                    end
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Credit counter
    // -------------------------------------------------------------------------
    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        if (state_q == S_INIT) begin
            // Returns that land here are dropped; TLX's advertised value wins.
            credit_d = CREDIT_W'(tlx_afu_cmd_initial_credit);
        end else if (any_grant && !tlx_afu_cmd_credit) begin
            credit_d = credit_q - CREDIT_W'(1);
        end else if (!any_grant && tlx_afu_cmd_credit) begin
            if (credit_q == CREDIT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                credit_d = credit_q + CREDIT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Command output register
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_valid_d = any_grant;
        cmd_bus_d   = cmd_bus_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                cmd_bus_d = req_cmd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            gap_q       <= '0;
            ptr_q       <= RR_WR;
            credit_q    <= '0;
            ovf_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_bus_q   <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
            ovf_q       <= ovf_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_bus_q   <= cmd_bus_d;
        end
    end

    assign actag_ready       = grant[0];
    assign wr_ready          = grant[1];
    assign rd_ready          = grant[2];
    assign intrp_ready       = grant[3];
    assign afu_tlx_cmd_valid = cmd_valid_q;
    assign afu_tlx_cmd_bus   = cmd_bus_q;
    assign credit_cnt        = credit_q;
    assign credit_ovf_err    = ovf_q;

    // -------------------------------------------------------------------------
    // Grant statistics
    // -------------------------------------------------------------------------
`ifdef BRDG_CMD_ARB_STAT_EN
    logic [NUM_REQ-1:0][31:0] stat_q, stat_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            // 32-bit add wraps naturally from 0xFFFFFFFF to 0.
            stat_d[i] = stat_q[i] + 32'(grant[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign grant_cnt_actag = stat_q[0];
    assign grant_cnt_wr    = stat_q[1];
    assign grant_cnt_rd    = stat_q[2];
    assign grant_cnt_intrp = stat_q[3];
`else
    assign grant_cnt_actag = 32'd0;
    assign grant_cnt_wr    = 32'd0;
    assign grant_cnt_rd    = 32'd0;
    assign grant_cnt_intrp = 32'd0;
`endif

endmodule

// File: tb/tb_brdg_tlx_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for brdg_tlx_cmd_arbiter. A cycle-level reference model tracks credits,
// the acTag quiet window (as an absolute cycle number), the round-robin
// position and the expected TLX output. It is checked against the DUT on every
// falling edge, and directed scenarios add literal expectations of their own.
// -----------------------------------------------------------------------------
module tb_brdg_tlx_cmd_arbiter;

    localparam int CMD_W     = 128;
    localparam int CREDIT_W  = 5;
    localparam int ACTAG_GAP = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          initial_credit;
    logic                tlx_credit;
    logic                actag_valid, wr_valid, rd_valid, intrp_valid;
    logic [CMD_W-1:0]    actag_cmd, wr_cmd, rd_cmd, intrp_cmd;
    logic                actag_ready, wr_ready, rd_ready, intrp_ready;
    logic                cmd_valid;
    logic [CMD_W-1:0]    cmd_bus;
    logic [CREDIT_W-1:0] credit_cnt;
    logic                ovf;
    logic [31:0]         gc_actag, gc_wr, gc_rd, gc_intrp;

    brdg_tlx_cmd_arbiter #(
        .CMD_W(CMD_W), .CREDIT_W(CREDIT_W), .ACTAG_GAP(ACTAG_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .tlx_afu_cmd_initial_credit(initial_credit),
        .tlx_afu_cmd_credit(tlx_credit),
        .actag_valid(actag_valid), .actag_cmd(actag_cmd), .actag_ready(actag_ready),
        .wr_valid(wr_valid), .wr_cmd(wr_cmd), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_cmd(rd_cmd), .rd_ready(rd_ready),
        .intrp_valid(intrp_valid), .intrp_cmd(intrp_cmd), .intrp_ready(intrp_ready),
        .afu_tlx_cmd_valid(cmd_valid), .afu_tlx_cmd_bus(cmd_bus),
        .credit_cnt(credit_cnt), .credit_ovf_err(ovf),
        .grant_cnt_actag(gc_actag), .grant_cnt_wr(gc_wr),
        .grant_cnt_rd(gc_rd), .grant_cnt_intrp(gc_intrp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    bit          chk_en = 0;
    bit          m_init = 1;
    int          m_cred = 0;
    int          m_ptr  = 0;      // next data requester to favour: 0 wr, 1 rd, 2 intrp
    longint      m_cyc  = 0;
    longint      m_block = 0;     // data grants forbidden while m_cyc <= m_block
    bit          m_ovf  = 0;
    bit          m_vld  = 0;
    logic [127:0] m_bus = '0;
    int unsigned m_stat [4] = '{0, 0, 0, 0};

    function automatic logic [127:0] cmd_of(input int i);
        case (i)
            0:       return actag_cmd;
            1:       return wr_cmd;
            2:       return rd_cmd;
            default: return intrp_cmd;
        endcase
    endfunction

    // Which requester the rules say gets the port right now, as {intrp,rd,wr,actag}.
    function automatic logic [3:0] exp_ready();
        logic [2:0] dv;
        int         j;
        dv = {intrp_valid, rd_valid, wr_valid};
        if (rst || m_init || m_cred == 0) return 4'b0000;
        if (actag_valid) return 4'b0001;
        if (m_cyc <= m_block) return 4'b0000;
        for (int k = 0; k < 3; k++) begin
            j = (m_ptr + k) % 3;
            if (dv[j]) return 4'(2 << j);
        end
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        logic [3:0] g;
        g = exp_ready();
        if (rst) begin
            chk_en  = 1;
            m_init  = 1;
            m_cred  = 0;
            m_ptr   = 0;
            m_block = m_cyc;
            m_ovf   = 0;
            m_vld   = 0;
            m_bus   = '0;
            for (int i = 0; i < 4; i++) m_stat[i] = 0;
        end else if (m_init) begin
            m_init = 0;
            m_cred = int'(initial_credit);
            m_vld  = 0;
        end else begin
            m_vld = (g != 0);
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    m_bus = cmd_of(i);
                    m_stat[i]++;
                    if (i == 0) m_block = m_cyc + ACTAG_GAP;
                    else        m_ptr   = i % 3;
                end
            end
            if (g != 0 && !tlx_credit)       m_cred--;
            else if (g == 0 && tlx_credit) begin
                if (m_cred == 16) m_ovf = 1;
                else              m_cred++;
            end
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 128'({intrp_ready, rd_ready, wr_ready, actag_ready}), 128'(exp_ready()));
            chk("cmd_valid", 128'(cmd_valid), 128'(m_vld));
            chk("cmd_bus", cmd_bus, m_bus);
            chk("credit_cnt", 128'(credit_cnt), 128'(m_cred));
            chk("credit_ovf_err", 128'(ovf), 128'(m_ovf));
`ifdef BRDG_CMD_ARB_STAT_EN
            chk("grant_cnt", {gc_actag, gc_wr, gc_rd, gc_intrp},
                {m_stat[0], m_stat[1], m_stat[2], m_stat[3]});
`else
            chk("grant_cnt", {gc_actag, gc_wr, gc_rd, gc_intrp}, 128'd0);
`endif
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first S_RUN cycle.
    task automatic do_reset(input logic [3:0] ic);
        rst = 1'b1;
        initial_credit = ic;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int         n;
        logic [3:0] seq [6];
        logic [3:0] exp_seq [6];

        rst = 1'b1; initial_credit = 4'd0; tlx_credit = 1'b0;
        actag_valid = 0; wr_valid = 0; rd_valid = 0; intrp_valid = 0;
        actag_cmd = 128'hAAAA_0001_0000_0000_0000_0000_0000_00A1;
        wr_cmd    = 128'h1111_0002_0000_0000_0000_0000_0000_00B2;
        rd_cmd    = 128'h2222_0003_0000_0000_0000_0000_0000_00C3;
        intrp_cmd = 128'h3333_0004_0000_0000_0000_0000_0000_00D4;

        // Reset state.
        tick();
        @(negedge clk);
        chk("rst_credit", 128'(credit_cnt), 128'd0);
        chk("rst_valid", 128'(cmd_valid), 128'd0);
        chk("rst_bus", cmd_bus, 128'd0);

        // Init credits: 3 credits, wr held for 5 cycles.
        do_reset(4'd3);
        wr_valid = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n += int'(wr_ready);
            tick();
        end
        chk("init_wr_grants", 128'(n), 128'd3);
        @(negedge clk);
        chk("init_credit_zero", 128'(credit_cnt), 128'd0);
        tick();
        tlx_credit = 1'b1;
        @(negedge clk);
        chk("no_grant_at_zero", 128'(wr_ready), 128'd0);
        tick();
        tlx_credit = 1'b0;
        @(negedge clk);
        chk("grant_after_return", 128'(wr_ready), 128'd1);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("return_grant_issued", 128'(cmd_valid), 128'd1);
        chk("return_grant_bus", cmd_bus, wr_cmd);
        tick();

        // Round-robin with all three data requesters.
        do_reset(4'd8);
        wr_valid = 1; rd_valid = 1; intrp_valid = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq[i] = {intrp_ready, rd_ready, wr_ready, actag_ready};
            tick();
        end
        wr_valid = 0; rd_valid = 0; intrp_valid = 0;
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order_%0d", i), 128'(seq[i]), 128'(exp_seq[i]));

        // acTag priority and quiet gap.
        do_reset(4'd8);
        actag_valid = 1; wr_valid = 1;
        @(negedge clk);
        chk("actag_prio_actag", 128'(actag_ready), 128'd1);
        chk("actag_prio_wr", 128'(wr_ready), 128'd0);
        tick();
        actag_valid = 0;
        @(negedge clk);
        chk("gap_t1_wr", 128'(wr_ready), 128'd0);
        chk("gap_t1_valid", 128'(cmd_valid), 128'd1);
        chk("gap_t1_bus", cmd_bus, actag_cmd);
        tick();
        @(negedge clk);
        chk("gap_t2_wr", 128'(wr_ready), 128'd0);
        tick();
        @(negedge clk);
        chk("gap_t3_wr", 128'(wr_ready), 128'd1);
        tick();
        wr_valid = 0;
        tick();

        // Credit corner at 16.
        do_reset(4'd15);
        tlx_credit = 1;
        tick();
        tlx_credit = 0;
        @(negedge clk);
        chk("credit_16", 128'(credit_cnt), 128'd16);
        tick();
        wr_valid = 1; tlx_credit = 1;
        @(negedge clk);
        chk("corner_grant", 128'(wr_ready), 128'd1);
        tick();
        wr_valid = 0; tlx_credit = 0;
        @(negedge clk);
        chk("corner_stay_16", 128'(credit_cnt), 128'd16);
        chk("corner_no_ovf", 128'(ovf), 128'd0);
        tick();
        tlx_credit = 1;
        tick();
        tlx_credit = 0;
        @(negedge clk);
        chk("ovf_credit_16", 128'(credit_cnt), 128'd16);
        chk("ovf_set", 128'(ovf), 128'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("ovf_sticky", 128'(ovf), 128'd1);
        tick();

        // Reset mid-stream.
        do_reset(4'd5);
        wr_valid = 1;
        @(negedge clk);
        chk("mid_first_grant", 128'(wr_ready), 128'd1);
        tick();
        rst = 1;
        @(negedge clk);
        chk("mid_rst_no_ready", 128'(wr_ready), 128'd0);
        tick();
        initial_credit = 4'd6;
        @(negedge clk);
        chk("mid_no_cmd", 128'(cmd_valid), 128'd0);
        chk("mid_credit_0", 128'(credit_cnt), 128'd0);
        chk("mid_ovf_clr", 128'(ovf), 128'd0);
        tick();
        rst = 0; tlx_credit = 1;
        @(negedge clk);
        chk("init_cycle_no_grant", 128'(wr_ready), 128'd0);
        tick();
        tlx_credit = 0;
        @(negedge clk);
        chk("reload_credit", 128'(credit_cnt), 128'd6);
        chk("reload_grant", 128'(wr_ready), 128'd1);
        tick();
        wr_valid = 0;
        tick();

        // Statistics: 4 rd grants and 1 actag grant.
        do_reset(4'd8);
        rd_valid = 1;
        repeat (4) tick();
        rd_valid = 0;
        actag_valid = 1;
        tick();
        actag_valid = 0;
        tick();
        @(negedge clk);
`ifdef BRDG_CMD_ARB_STAT_EN
        chk("stat_actag", 128'(gc_actag), 128'd1);
        chk("stat_wr", 128'(gc_wr), 128'd0);
        chk("stat_rd", 128'(gc_rd), 128'd4);
        chk("stat_intrp", 128'(gc_intrp), 128'd0);
`else
        chk("stat_off", {gc_actag, gc_wr, gc_rd, gc_intrp}, 128'd0);
`endif
        chk("stat_credit", 128'(credit_cnt), 128'd3);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
